// File: rtl/hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO write-port sequencer: op codes, FSM states, constants.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package hilo_ctrl_pkg;

  // HILO-class op codes as presented on op_i
  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  // Quotient reported when the divisor is zero
  localparam logic [31:0] DIV0_QUOT = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIV_RUN = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/hilo_ctrl_div_iter.sv
// Unsigned restoring divider core, one shift-subtract iteration per cycle.
// Latency: DATA_W cycles after start; done flags the cycle of the final iteration.
// Backpressure: none; abort (or rst) drops an in-flight division immediately.
module hilo_ctrl_div_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] dvs;
  logic [CNT_W-1:0]  count;
  logic              running;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;

  // Trial subtraction of the divisor from the partial remainder with the next dividend bit
  always_comb begin
    shifted = {rem, quo[DATA_W-1]};
    diff    = shifted - {1'b0, dvs};
  end

  assign done      = running && (count == LAST);
  assign quotient  = quo;
  assign remainder = rem;

  // Load on start, then restore-or-keep each cycle; quotient bits shift in from the right
  always_ff @(posedge clk) begin
    if (rst) begin
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      count   <= '0;
      running <= 1'b0;
    end else if (abort) begin
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      quo     <= dividend;
      rem     <= '0;
      dvs     <= divisor;
      count   <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (!diff[DATA_W]) begin
        rem <= diff[DATA_W-1:0];
        quo <= {quo[DATA_W-2:0], 1'b1};
      end else begin
        rem <= shifted[DATA_W-1:0];
        quo <= {quo[DATA_W-2:0], 1'b0};
      end
      if (count == LAST) begin
        count   <= '0;
        running <= 1'b0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO write-port sequencer: single-cycle mult/move writes, 32-cycle restoring divide with stall.
// Latency: mult/move 0 cycles; div writes 33 cycles after issue (1 cycle on zero divisor).
// Backpressure: stall_o holds EX during a divide; flush_i/rst abort it. Macro HILO_MADD_EN enables MADD/MSUB ops.
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic [3:0]          op_i,
  input  logic [DATA_W-1:0]   src_a,
  input  logic [DATA_W-1:0]   src_b,
  input  logic                flush_i,
  input  logic [2*DATA_W-1:0] hilo_cur,
  output logic                hilo_we,
  output logic [2*DATA_W-1:0] hilo_wdata,
  output logic                stall_o,
  output logic                busy_o
);

  state_t              state, state_nxt;
  logic                div_start, lat_en, div_done;
  logic                op_signed;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [DATA_W-1:0]   a_lat;
  logic                neg_q, neg_r, dz;
  logic [DATA_W-1:0]   quo, rem, q_fix, r_fix;
  logic [2*DATA_W-1:0] prod_s, prod_u, div_result;

  assign prod_s    = $signed(src_a) * $signed(src_b);
  assign prod_u    = {{DATA_W{1'b0}}, src_a} * {{DATA_W{1'b0}}, src_b};
  assign op_signed = (op_i == OP_DIV);
  // Magnitudes for the unsigned core; the most negative value maps onto itself as unsigned
  assign abs_a     = (op_signed && src_a[DATA_W-1]) ? -src_a : src_a;
  assign abs_b     = (op_signed && src_b[DATA_W-1]) ? -src_b : src_b;

  hilo_ctrl_div_iter #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (flush_i),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (quo),
    .remainder (rem),
    .done      (div_done)
  );

  // Sign fixup of the unsigned core result, or the fixed divide-by-zero pattern
  always_comb begin
    q_fix      = neg_q ? -quo : quo;
    r_fix      = neg_r ? -rem : rem;
    div_result = dz ? {a_lat, DIV0_QUOT} : {r_fix, q_fix};
  end

  // State register and per-division operand/sign latches
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      a_lat <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (lat_en) begin
        a_lat <= src_a;
        neg_q <= op_signed && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
        neg_r <= op_signed && src_a[DATA_W-1];
        dz    <= (src_b == '0);
      end
    end
  end

  // Op decode, next state and write/stall outputs; flush and reset win over everything
  always_comb begin
    state_nxt  = state;
    hilo_we    = 1'b0;
    hilo_wdata = '0;
    stall_o    = 1'b0;
    div_start  = 1'b0;
    lat_en     = 1'b0;
    busy_o     = (state != ST_IDLE);
    if (rst || flush_i) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            case (op_i)
              OP_MULT: begin
                hilo_we    = 1'b1;
                hilo_wdata = prod_s;
              end
              OP_MULTU: begin
                hilo_we    = 1'b1;
                hilo_wdata = prod_u;
              end
              OP_MTHI: begin
                hilo_we    = 1'b1;
                hilo_wdata = {src_a, hilo_cur[DATA_W-1:0]};
              end
              OP_MTLO: begin
                hilo_we    = 1'b1;
                hilo_wdata = {hilo_cur[2*DATA_W-1:DATA_W], src_a};
              end
`ifdef HILO_MADD_EN
              OP_MADD: begin
                hilo_we    = 1'b1;
                hilo_wdata = hilo_cur + prod_s;
              end
              OP_MADDU: begin
                hilo_we    = 1'b1;
                hilo_wdata = hilo_cur + prod_u;
              end
              OP_MSUB: begin
                hilo_we    = 1'b1;
                hilo_wdata = hilo_cur - prod_s;
              end
              OP_MSUBU: begin
                hilo_we    = 1'b1;
                hilo_wdata = hilo_cur - prod_u;
              end
`endif
              OP_DIV, OP_DIVU: begin
                stall_o = 1'b1;
                lat_en  = 1'b1;
                if (src_b != '0) begin
                  div_start = 1'b1;
                  state_nxt = ST_DIV_RUN;
                end else begin
                  state_nxt = ST_DONE;
                end
              end
              default: ;
            endcase
          end
        end
        ST_DIV_RUN: begin
          stall_o = 1'b1;
          if (div_done) state_nxt = ST_DONE;
        end
        ST_DONE: begin
          hilo_we    = 1'b1;
          hilo_wdata = div_result;
          state_nxt  = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed self-checking bench for hilo_ctrl: mult/move, divide timing and results, flush/reset abort.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Build with HILO_MADD_EN to exercise the multiply-accumulate expectations.
module tb_hilo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [3:0]  op_i;
  logic [31:0] src_a, src_b;
  logic        flush_i;
  logic [63:0] hilo_cur;
  logic        hilo_we;
  logic [63:0] hilo_wdata;
  logic        stall_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hilo_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .op_i       (op_i),
    .src_a      (src_a),
    .src_b      (src_b),
    .flush_i    (flush_i),
    .hilo_cur   (hilo_cur),
    .hilo_we    (hilo_we),
    .hilo_wdata (hilo_wdata),
    .stall_o    (stall_o),
    .busy_o     (busy_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one op for a single cycle and check the same-cycle write
  task automatic one_cycle(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic exp_we, input logic [63:0] exp_w);
    tick();
    valid_i = 1'b1; op_i = op; src_a = a; src_b = b;
    #4;
    check({tag, "_we"}, hilo_we, exp_we);
    if (exp_we) check({tag, "_wdata"}, hilo_wdata, exp_w);
    check({tag, "_stall"}, stall_o, 1'b0);
  endtask

  // Issue a divide, hold valid through DONE, and check stall length, write cycle and data
  task automatic run_div(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_w, input int exp_cyc);
    int  stalls;
    int  cyc;
    bit  seen;
    tick();
    valid_i = 1'b1; op_i = op; src_a = a; src_b = b;
    #4;
    check({tag, "_issue_stall"}, stall_o, 1'b1);
    stalls = stall_o ? 1 : 0;
    cyc    = -1;
    seen   = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      tick();
      #4;
      if (hilo_we) begin
        seen = 1'b1;
        cyc  = i;
      end else if (stall_o) begin
        stalls++;
      end
    end
    check({tag, "_write_cycle"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_cyc));
    check({tag, "_wdata"}, hilo_wdata, exp_w);
    check({tag, "_done_stall"}, stall_o, 1'b0);
    check({tag, "_done_busy"}, busy_o, 1'b1);
    tick();
    valid_i = 1'b0; op_i = 4'd0;
    #4;
    check({tag, "_after_busy"}, busy_o, 1'b0);
    check({tag, "_after_we"}, hilo_we, 1'b0);
  endtask

  initial begin
    int we_seen;
    rst = 1'b1; valid_i = 1'b0; op_i = 4'd0; src_a = '0; src_b = '0;
    flush_i = 1'b0; hilo_cur = '0;

    // Reset state
    tick();
    tick();
    #4;
    check("rst_we", hilo_we, 1'b0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_wdata", hilo_wdata, 64'h0);
    tick();
    rst = 1'b0;

    // Multiply and move paths
    one_cycle("mult",  4'd1, 32'hFFFFFFFE, 32'd3, 1'b1, 64'hFFFFFFFF_FFFFFFFA);
    one_cycle("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 1'b1, 64'h00000002_FFFFFFFA);
    one_cycle("mult_neg", 4'd1, 32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000);
    hilo_cur = 64'h11111111_22222222;
    one_cycle("mthi", 4'd5, 32'h0000AAAA, 32'd0, 1'b1, 64'h0000AAAA_22222222);
    one_cycle("mtlo", 4'd6, 32'h0000BBBB, 32'd0, 1'b1, 64'h11111111_0000BBBB);
    one_cycle("op_none", 4'd0, 32'd5, 32'd5, 1'b0, 64'h0);
    one_cycle("op_12", 4'd12, 32'd5, 32'd5, 1'b0, 64'h0);
    tick();
    valid_i = 1'b0; op_i = 4'd1;
    #4;
    check("novalid_we", hilo_we, 1'b0);

    // Multiply-accumulate ops
    hilo_cur = 64'h00000000_00000010;
`ifdef HILO_MADD_EN
    one_cycle("msub",  4'd9, 32'd3, 32'd5, 1'b1, 64'h00000000_00000001);
    one_cycle("madd",  4'd7, 32'hFFFFFFFF, 32'd2, 1'b1, 64'h00000000_0000000E);
    one_cycle("maddu", 4'd8, 32'hFFFFFFFF, 32'd2, 1'b1, 64'h00000002_0000000E);
    hilo_cur = 64'h0;
    one_cycle("msubu", 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000001_FFFFFFFF);
`else
    one_cycle("msub_off",  4'd9, 32'd3, 32'd5, 1'b0, 64'h0);
    one_cycle("madd_off",  4'd7, 32'hFFFFFFFF, 32'd2, 1'b0, 64'h0);
    one_cycle("maddu_off", 4'd8, 32'hFFFFFFFF, 32'd2, 1'b0, 64'h0);
    one_cycle("msubu_off", 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'h0);
`endif

    // Divides
    run_div("div_m7_2",  4'd3, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
    run_div("divu_100_7", 4'd4, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
    run_div("div_7_m2",  4'd3, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
    run_div("div_min_1", 4'd3, 32'h80000000, 32'd1, 64'h00000000_80000000, 33);
    run_div("divu_5_0",  4'd4, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1);

    // Flush at DIV_RUN count=10 (cycle 11 after issue)
    tick();
    valid_i = 1'b1; op_i = 4'd3; src_a = 32'd1000; src_b = 32'd3;
    for (int i = 1; i <= 11; i++) tick();
    flush_i = 1'b1;
    #4;
    check("flush_stall", stall_o, 1'b0);
    check("flush_we", hilo_we, 1'b0);
    tick();
    flush_i = 1'b0; valid_i = 1'b0; op_i = 4'd0;
    #4;
    check("flush_busy_next", busy_o, 1'b0);
    we_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      #4;
      if (hilo_we) we_seen++;
    end
    check("flush_no_write", 64'(we_seen), 64'd0);
    one_cycle("mult_post_flush", 4'd1, 32'd7, 32'd6, 1'b1, 64'h00000000_0000002A);

    // Flush in IDLE blocks a new op
    tick();
    valid_i = 1'b1; op_i = 4'd3; src_a = 32'd9; src_b = 32'd2; flush_i = 1'b1;
    #4;
    check("idle_flush_stall", stall_o, 1'b0);
    tick();
    valid_i = 1'b0; op_i = 4'd0; flush_i = 1'b0;
    #4;
    check("idle_flush_busy", busy_o, 1'b0);

    // Reset mid-division
    tick();
    valid_i = 1'b1; op_i = 4'd4; src_a = 32'd1000; src_b = 32'd3;
    for (int i = 1; i <= 5; i++) tick();
    rst = 1'b1;
    #4;
    check("rst_mid_we", hilo_we, 1'b0);
    check("rst_mid_stall", stall_o, 1'b0);
    tick();
    rst = 1'b0; valid_i = 1'b0; op_i = 4'd0;
    #4;
    check("rst_mid_busy", busy_o, 1'b0);
    run_div("divu_post_rst", 4'd4, 32'd1000, 32'd3, 64'h00000001_0000014D, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
